alu_arbiter: RTL and testbench

- Shares the single rv32i ALU (srcA/srcB/ALUControl → result) between two requesters, e.g. the execute stage and an address/branch-target helper.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin; operands are registered before reaching the ALU, and the result is registered before return.
- Sits between the control/datapath requesters and the ALU instance.

---
 rtl/alu_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
//
// Purpose:
//   Two requesters each present an operation (srcA, srcB, ALUControl) on a
//   valid/ready request channel. One operation is accepted in IDLE, its
//   operands are registered and presented to the ALU for one ISSUE cycle,
//   the ALU result is registered, and it is returned on the winner's
//   valid/ready response channel (RESP). Ties go to the requester named by
//   prio, which flips to the other requester after every completed response.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid/ready         request handshake for requester N (ready is combinational, IDLE only)
//   reqN_a/b/ctrl            requester N srcA / srcB / ALUControl
//   rspN_valid/ready         response handshake for requester N
//   rspN_result              registered result (0 unless requester N's response is pending)
//   rspN_err                 illegal-ctrl flag (only with ALU_ARB_ILLEGAL_CHK_EN)
//   alu_srcA/srcB/ALUControl registered operands to the ALU
//   alu_result               combinational ALU result
//
// Configuration:
//   ALU_ARB_ILLEGAL_CHK_EN   when defined, ctrl codes other than 0,1,2,3,5 bypass the
//                            ALU and return result 0 with rspN_err set.

module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [WIDTH-1:0]  rsp0_result,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp1_result,

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  output logic              rsp0_err,
  output logic              rsp1_err,
`endif

  output logic [WIDTH-1:0]  alu_srcA,
  output logic [WIDTH-1:0]  alu_srcB,
  output logic [CTRL_W-1:0] alu_ALUControl,
  input  logic [WIDTH-1:0]  alu_result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t              state_q;
  logic                prio_q;
  logic                grant_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [CTRL_W-1:0]   ctrl_q;
  logic [WIDTH-1:0]    res_q;
  // One-hot response-valid per requester; only the granted bit is ever set.
  logic [1:0]          vld_q;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
  logic [1:0]          err_q;
`endif

  // Next-state candidates for the IDLE acceptance.
  logic                idle_d;
  logic                win1_d;
  logic                accept_d;
  logic [WIDTH-1:0]    a_d;
  logic [WIDTH-1:0]    b_d;
  logic [CTRL_W-1:0]   ctrl_d;
  logic                rsp_done_d;

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  function automatic logic ctrl_legal(input logic [CTRL_W-1:0] c);
    ctrl_legal = (c == CTRL_W'(0)) || (c == CTRL_W'(1)) || (c == CTRL_W'(2)) ||
                 (c == CTRL_W'(3)) || (c == CTRL_W'(5));
  endfunction
`endif

  always_comb begin
    idle_d     = (state_q == S_IDLE);
    // Requester 1 wins when it is the only one asking, or when both ask and prio names it.
    win1_d     = req1_valid && (!req0_valid || prio_q);
    accept_d   = idle_d && (req0_valid || req1_valid);
    a_d        = win1_d ? req1_a    : req0_a;
    b_d        = win1_d ? req1_b    : req0_b;
    ctrl_d     = win1_d ? req1_ctrl : req0_ctrl;
    rsp_done_d = grant_q ? rsp1_ready : rsp0_ready;
  end

  assign req0_ready = idle_d && req0_valid && !win1_d;
  assign req1_ready = idle_d && win1_d;

  assign rsp0_valid  = vld_q[0];
  assign rsp1_valid  = vld_q[1];
  assign rsp0_result = vld_q[0] ? res_q : '0;
  assign rsp1_result = vld_q[1] ? res_q : '0;

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  assign rsp0_err = err_q[0];
  assign rsp1_err = err_q[1];
`endif

  // The ALU only ever sees the operand registers, never the live request inputs.
  assign alu_srcA       = a_q;
  assign alu_srcB       = b_q;
  assign alu_ALUControl = ctrl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
      grant_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      res_q   <= '0;
      vld_q   <= 2'b00;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
      err_q   <= 2'b00;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            grant_q <= win1_d;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
            if (ctrl_legal(ctrl_d)) begin
              a_q     <= a_d;
              b_q     <= b_d;
              ctrl_q  <= ctrl_d;
              state_q <= S_ISSUE;
            end else begin
              // Illegal code: answer straight away with a zero result and leave
              // the ALU operands untouched.
              res_q   <= '0;
              vld_q   <= win1_d ? 2'b10 : 2'b01;
              err_q   <= win1_d ? 2'b10 : 2'b01;
              state_q <= S_RESP;
            end
`else
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            state_q <= S_ISSUE;
`endif
          end
        end

        S_ISSUE: begin
          res_q   <= alu_result;
          vld_q   <= grant_q ? 2'b10 : 2'b01;
          state_q <= S_RESP;
        end

        S_RESP: begin
          if (rsp_done_d) begin
            vld_q   <= 2'b00;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
            err_q   <= 2'b00;
`endif
            // Hand priority to the other requester so continuous contention alternates.
            prio_q  <= ~grant_q;
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [31:0] req0_a, req0_b, rsp0_result;
  logic [2:0]  req0_ctrl;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [31:0] req1_a, req1_b, rsp1_result;
  logic [2:0]  req1_ctrl;
  logic [31:0] alu_srcA, alu_srcB, alu_result;
  logic [2:0]  alu_ALUControl;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
  logic        rsp0_err, rsp1_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .CTRL_W(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
`endif
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ALUControl(alu_ALUControl), .alu_result(alu_result)
  );

  // Reference rv32i-style ALU the arbiter is shared in front of.
  always_comb begin
    case (alu_ALUControl)
      3'd0:    alu_result = alu_srcA + alu_srcB;
      3'd1:    alu_result = alu_srcA - alu_srcB;
      3'd2:    alu_result = alu_srcA & alu_srcB;
      3'd3:    alu_result = alu_srcA | alu_srcB;
      3'd4:    alu_result = alu_srcA ^ alu_srcB;
      3'd5:    alu_result = {31'd0, ($signed(alu_srcA) < $signed(alu_srcB))};
      default: alu_result = 32'd0;
    endcase
  end

  typedef struct {
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req0_ready"},  {31'd0, req0_ready}, 32'd0);
    check({tag, " req1_ready"},  {31'd0, req1_ready}, 32'd0);
    check({tag, " rsp0_valid"},  {31'd0, rsp0_valid}, 32'd0);
    check({tag, " rsp1_valid"},  {31'd0, rsp1_valid}, 32'd0);
    check({tag, " rsp0_result"}, rsp0_result, 32'd0);
    check({tag, " rsp1_result"}, rsp1_result, 32'd0);
    check({tag, " alu_srcA"},    alu_srcA, 32'd0);
    check({tag, " alu_srcB"},    alu_srcB, 32'd0);
    check({tag, " alu_ctrl"},    {29'd0, alu_ALUControl}, 32'd0);
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    check_all_zero(tag);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Waits on negedges for the selected requester's ready; ok=0 on timeout.
  task automatic wait_ready(input int sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((sel == 0 && req0_ready) || (sel == 1 && req1_ready)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c, input logic [31:0] exp, input string tag);
    bit ok;
    if (sel == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = c;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = c;
    end
    wait_ready(sel, ok);
    check({tag, " ready seen"}, {31'd0, ok}, 32'd1);
    check({tag, " other ready"}, {31'd0, (sel == 0) ? req1_ready : req0_ready}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check({tag, " issue srcA"}, alu_srcA, a);
    check({tag, " issue srcB"}, alu_srcB, b);
    check({tag, " issue ctrl"}, {29'd0, alu_ALUControl}, {29'd0, c});
    check({tag, " issue rsp0_valid"}, {31'd0, rsp0_valid}, 32'd0);
    check({tag, " issue rsp1_valid"}, {31'd0, rsp1_valid}, 32'd0);
    @(posedge clk); #1;
    check({tag, " resp own valid"}, {31'd0, (sel == 0) ? rsp0_valid : rsp1_valid}, 32'd1);
    check({tag, " resp result"}, (sel == 0) ? rsp0_result : rsp1_result, exp);
    check({tag, " resp other valid"}, {31'd0, (sel == 0) ? rsp1_valid : rsp0_valid}, 32'd0);
    check({tag, " resp other result"}, (sel == 0) ? rsp1_result : rsp0_result, 32'd0);
    @(posedge clk); #1;
    check({tag, " done valid"}, {31'd0, (sel == 0) ? rsp0_valid : rsp1_valid}, 32'd0);
  endtask

  initial begin
    bit ok;
    int who;

    vecs[0] = '{sel: 0, a: 32'd2,          b: 32'd1,          ctrl: 3'd0, exp: 32'd3};
    vecs[1] = '{sel: 1, a: 32'd2,          b: 32'd1,          ctrl: 3'd1, exp: 32'd1};
    vecs[2] = '{sel: 1, a: 32'd2,          b: 32'd1,          ctrl: 3'd5, exp: 32'd0};
    vecs[3] = '{sel: 1, a: 32'd2,          b: 32'd1,          ctrl: 3'd3, exp: 32'd3};
    vecs[4] = '{sel: 0, a: 32'hFFFF_FFFF,  b: 32'd1,          ctrl: 3'd0, exp: 32'd0};
    vecs[5] = '{sel: 0, a: 32'd0,          b: 32'd1,          ctrl: 3'd1, exp: 32'hFFFF_FFFF};
    vecs[6] = '{sel: 1, a: 32'h8000_0000,  b: 32'd1,          ctrl: 3'd5, exp: 32'd1};
    vecs[7] = '{sel: 0, a: 32'h0000_F0F0,  b: 32'h0000_FF00,  ctrl: 3'd2, exp: 32'h0000_F000};

    rst = 1'b0;
    idle_inputs();
    #2;
    do_reset("reset");

    // Directed single-requester vectors.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].ctrl, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Fairness: both requesters continuously valid alternate 0,1,0,1.
    do_reset("reset2");
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd3; req0_ctrl = 3'd0;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd3; req1_ctrl = 3'd1;
    for (int i = 0; i < 4; i++) begin
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin
          ok = 1'b1;
          break;
        end
      end
      check($sformatf("rr%0d ready seen", i), {31'd0, ok}, 32'd1);
      check($sformatf("rr%0d single ready", i), {31'd0, req0_ready && req1_ready}, 32'd0);
      who = req1_ready ? 1 : 0;
      check($sformatf("rr%0d grant", i), who, i % 2);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check($sformatf("rr%0d own valid", i), {31'd0, (who == 0) ? rsp0_valid : rsp1_valid}, 32'd1);
      check($sformatf("rr%0d result", i), (who == 0) ? rsp0_result : rsp1_result,
            (who == 0) ? 32'd13 : 32'd7);
      check($sformatf("rr%0d other valid", i), {31'd0, (who == 0) ? rsp1_valid : rsp0_valid}, 32'd0);
      check($sformatf("rr%0d other result", i), (who == 0) ? rsp1_result : rsp0_result, 32'd0);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure on rsp0 while req1 waits.
    do_reset("reset3");
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd1; req0_ctrl = 3'd0;
    wait_ready(0, ok);
    check("bp req0 ready", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd1; req1_ctrl = 3'd3;
    check("bp issue req1_ready", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d rsp0_valid", i), {31'd0, rsp0_valid}, 32'd1);
      check($sformatf("bp%0d rsp0_result", i), rsp0_result, 32'd3);
      check($sformatf("bp%0d req1_ready", i), {31'd0, req1_ready}, 32'd0);
    end
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    check("bp released rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("bp idle req1_ready", {31'd0, req1_ready}, 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    check("bp rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    check("bp rsp1_result", rsp1_result, 32'd3);
    @(posedge clk); #1;

    // Reset asserted during ISSUE drops the operation.
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd6; req0_ctrl = 3'd0;
    wait_ready(0, ok);
    check("mid ready", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check("mid issue srcA", alu_srcA, 32'd5);
    rst = 1'b1;
    #1;
    check_all_zero("mid rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("mid%0d no rsp0", i), {31'd0, rsp0_valid}, 32'd0);
    end
    @(posedge clk); #1;
    run_op(0, 32'd7, 32'd8, 3'd0, 32'd15, "after rst");

`ifdef ALU_ARB_ILLEGAL_CHK_EN
    // Illegal ctrl code short-circuits to RESP with err set.
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_ctrl = 3'd7;
    wait_ready(0, ok);
    check("ill ready", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    check("ill rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("ill rsp0_err", {31'd0, rsp0_err}, 32'd1);
    check("ill rsp0_result", rsp0_result, 32'd0);
    check("ill alu ctrl", {29'd0, alu_ALUControl}, 32'd0);
    check("ill alu srcA", alu_srcA, 32'd7);
    check("ill rsp1_err", {31'd0, rsp1_err}, 32'd0);
    @(posedge clk); #1;
    check("ill err clear", {31'd0, rsp0_err}, 32'd0);
    check("ill valid clear", {31'd0, rsp0_valid}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
